branch_pc_controller: RTL and testbench

- Owns the program counter and sequences control flow for the single-cycle ARM-subset core.
- Each cycle it advances PC by 4, or redirects it to PC+4 plus the word-scaled, sign-extended 8-bit branch offset.
- On a taken redirect it asserts a one-cycle squash of the wrong-path instruction already fetched.
- Stalls on instruction/data memory BUSYWAIT.

---
 rtl/branch_pc_controller_pkg.sv | 19 +
 rtl/branch_pc_controller_offset_sext_shl2.sv | 19 +
 rtl/branch_pc_controller.sv | 133 +++++++++++++
 tb/tb_branch_pc_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/branch_pc_controller_pkg.sv
// -----------------------------------------------------------------------------
// branch_pc_controller_pkg
// Shared definitions for the program-counter / branch sequencing block:
//   - state_t     : 2-bit control state (S_IDLE, S_RUN, S_FLUSH; 2'd3 illegal)
//   - WORD_BYTES  : bytes per instruction word (sequential PC step)
//   - RESET_VECTOR_DEFAULT : PC value loaded on reset unless overridden
// -----------------------------------------------------------------------------
package branch_pc_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam int          WORD_BYTES           = 4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/branch_pc_controller_offset_sext_shl2.sv
// -----------------------------------------------------------------------------
// offset_sext_shl2
// Turns a signed word offset into a signed byte offset: sign-extends OFF_W bits
// to DATA_W bits and scales by 4 (<<2). Purely combinational.
// Ports:
//   offset     in  [OFF_W-1:0]  signed word offset
//   offset_ext out [DATA_W-1:0] signed byte offset
// -----------------------------------------------------------------------------
module offset_sext_shl2 #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 8
) (
  input  logic signed [OFF_W-1:0]  offset,
  output logic signed [DATA_W-1:0] offset_ext
);

  assign offset_ext = {{(DATA_W-OFF_W-2){offset[OFF_W-1]}}, offset, 2'b00};

endmodule

// File: rtl/branch_pc_controller.sv
// -----------------------------------------------------------------------------
// branch_pc_controller
// Owns the program counter of the single-cycle core. Each accepted cycle the PC
// advances by PC_STEP, or is redirected to PC+4 + (sign-extended OFFSET << 2).
// A taken redirect raises FLUSH for the wrong-path instruction already fetched;
// that squashed slot can never redirect. BUSYWAIT freezes all state.
//
// Optional feature macro: BRANCH_PC_STATS_EN
//   When defined, adds saturating 16-bit counters BR_TAKEN_CNT (accepted
//   redirects) and BR_FLUSH_CNT (cycles leaving the flush state).
//
// Ports:
//   CLK        in   core clock, rising edge
//   RESET      in   asynchronous active-low reset
//   BUSYWAIT   in   memory stall, 1 = hold all state
//   JUMP       in   unconditional branch (wins over everything)
//   BRANCH     in   branch-if-equal (taken when ZERO=1)
//   BRANCH_NE  in   branch-if-not-equal (taken when ZERO=0)
//   ZERO       in   ALU zero flag of the current instruction
//   OFFSET     in   [7:0] signed word offset
//   PC         out  [31:0] current fetch address, registered
//   PC_PLUS4   out  [31:0] PC + PC_STEP, combinational
//   FLUSH      out  squash instruction in fetch, registered
//   TAKEN      out  redirect accepted this cycle, combinational
//   BR_TAKEN_CNT / BR_FLUSH_CNT out [15:0] (only with BRANCH_PC_STATS_EN)
// -----------------------------------------------------------------------------
module branch_pc_controller
  import branch_pc_controller_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          PC_STEP      = WORD_BYTES  // only 4 is supported
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BUSYWAIT,
  input  logic               JUMP,
  input  logic               BRANCH,
  input  logic               BRANCH_NE,
  input  logic               ZERO,
  input  logic signed [7:0]  OFFSET,
  output logic        [31:0] PC,
  output logic        [31:0] PC_PLUS4,
  output logic               FLUSH,
  output logic               TAKEN
`ifdef BRANCH_PC_STATS_EN
  ,
  output logic        [15:0] BR_TAKEN_CNT,
  output logic        [15:0] BR_FLUSH_CNT
`endif
);

  state_t             state;
  logic               take_req;
  logic signed [31:0] offset_ext;
  logic        [31:0] target;

  offset_sext_shl2 #(
    .DATA_W (32),
    .OFF_W  (8)
  ) u_offset_sext_shl2 (
    .offset     (OFFSET),
    .offset_ext (offset_ext)
  );

  assign PC_PLUS4 = PC + 32'(PC_STEP);

  // JUMP alone makes the condition true, so it dominates any BRANCH/ZERO mix.
  assign take_req = JUMP | (BRANCH & ZERO) | (BRANCH_NE & ~ZERO);

  // Modulo-2^32 add: wrap in either direction is intentionally silent.
  assign target = PC_PLUS4 + $unsigned(offset_ext);

  // Only a running, unstalled slot may redirect; a squashed slot never does.
  assign TAKEN = (state == S_RUN) & ~BUSYWAIT & take_req;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
      PC    <= RESET_VECTOR;
      FLUSH <= 1'b0;
    end else begin
      case (state)
        // One settling edge after reset; PC stays on the reset vector.
        S_IDLE: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (!BUSYWAIT) begin
            if (take_req) begin
              PC    <= target;
              FLUSH <= 1'b1;
              state <= S_FLUSH;
            end else begin
              PC <= PC_PLUS4;
            end
          end
        end
        S_FLUSH: begin
          if (!BUSYWAIT) begin
            PC    <= PC_PLUS4;
            FLUSH <= 1'b0;
            state <= S_RUN;
          end
        end
        // Unreachable encoding: recover into normal sequencing.
        default: begin
          state <= S_RUN;
          FLUSH <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_PC_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic flush_leave;
  assign flush_leave = (state == S_FLUSH) & ~BUSYWAIT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      BR_TAKEN_CNT <= 16'd0;
      BR_FLUSH_CNT <= 16'd0;
    end else begin
      if (TAKEN)       BR_TAKEN_CNT <= sat_inc(BR_TAKEN_CNT);
      if (flush_leave) BR_FLUSH_CNT <= sat_inc(BR_FLUSH_CNT);
    end
  end
`endif

endmodule

// File: tb/tb_branch_pc_controller.sv
module tb_branch_pc_controller;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              busy, jump, br, bne, zero;
  logic signed [7:0] off;
  logic [31:0]       pc, pc_plus4;
  logic              flush, taken;
`ifdef BRANCH_PC_STATS_EN
  logic [15:0]       taken_cnt, flush_cnt;
`endif

  branch_pc_controller dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .BUSYWAIT  (busy),
    .JUMP      (jump),
    .BRANCH    (br),
    .BRANCH_NE (bne),
    .ZERO      (zero),
    .OFFSET    (off),
    .PC        (pc),
    .PC_PLUS4  (pc_plus4),
    .FLUSH     (flush),
    .TAKEN     (taken)
`ifdef BRANCH_PC_STATS_EN
    ,
    .BR_TAKEN_CNT (taken_cnt),
    .BR_FLUSH_CNT (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit check_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // m_started : first post-reset edge has happened
  // m_squash  : the slot now in fetch is wrong-path
  logic [31:0] m_pc;
  bit          m_started, m_squash;
  int          m_tc, m_fc;

  function automatic bit redirect(input logic j, input logic b, input logic n, input logic z);
    return j || (b && z) || (n && !z);
  endfunction

  function automatic logic [31:0] dest(input logic [31:0] p, input logic signed [7:0] o);
    int word_off;
    word_off = o;
    return p + 32'd4 + 32'(word_off * 4);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RV; m_started <= 1'b0; m_squash <= 1'b0; m_tc <= 0; m_fc <= 0;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (m_squash) begin
      if (!busy) begin
        m_pc <= m_pc + 32'd4; m_squash <= 1'b0;
        m_fc <= (m_fc < 65535) ? m_fc + 1 : m_fc;
      end
    end else if (!busy) begin
      if (redirect(jump, br, bne, zero)) begin
        m_pc <= dest(m_pc, off); m_squash <= 1'b1;
        m_tc <= (m_tc < 65535) ? m_tc + 1 : m_tc;
      end else begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("model_pc", pc, m_pc);
      check("model_pc_plus4", pc_plus4, m_pc + 32'd4);
      check("model_flush", {31'd0, flush}, {31'd0, m_squash});
      check("model_taken", {31'd0, taken},
            {31'd0, m_started && !m_squash && !busy && redirect(jump, br, bne, zero)});
`ifdef BRANCH_PC_STATS_EN
      check("model_taken_cnt", {16'd0, taken_cnt}, 32'(m_tc));
      check("model_flush_cnt", {16'd0, flush_cnt}, 32'(m_fc));
`endif
    end
  end

  // ---------------- directed helpers ----------------
  task automatic drive(input logic b, input logic j, input logic r, input logic n,
                       input logic z, input logic [7:0] o);
    busy = b; jump = j; br = r; bne = n; zero = z; off = o;
  endtask

  // Drive a cycle's inputs just after the edge, then stop at the following low phase.
  task automatic step(input logic b, input logic j, input logic r, input logic n,
                      input logic z, input logic [7:0] o);
    @(posedge clk); #1;
    drive(b, j, r, n, z, o);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] epc, input logic efl, input logic etk);
    check({name, "_pc"}, pc, epc);
    check({name, "_flush"}, {31'd0, flush}, {31'd0, efl});
    check({name, "_taken"}, {31'd0, taken}, {31'd0, etk});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #3;
    lit("in_reset", 32'h0, 1'b0, 1'b0);
    check_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    lit("idle", 32'h0, 1'b0, 1'b0);              // JUMP still high, ignored
    step(0, 0, 0, 0, 0, 8'h00); lit("seq0", 32'h0, 0, 0);
    step(0, 0, 0, 0, 0, 8'h00); lit("seq4", 32'h4, 0, 0);
    step(0, 1, 0, 0, 0, 8'h03); lit("jmp_fwd", 32'h8, 0, 1);
    step(0, 0, 0, 0, 0, 8'h00); lit("jmp_fwd_tgt", 32'h18, 1, 0);
    step(0, 0, 0, 0, 0, 8'h00); lit("jmp_fwd_next", 32'h1C, 0, 0);
    step(0, 0, 1, 0, 1, 8'hFE); lit("beq_taken", 32'h20, 0, 1);
    step(0, 0, 0, 0, 0, 8'h00); lit("beq_tgt", 32'h1C, 1, 0);
    step(0, 0, 0, 1, 0, 8'hFE); lit("bne_taken", 32'h20, 0, 1);
    step(0, 0, 0, 0, 0, 8'h00); lit("bne_tgt", 32'h1C, 1, 0);
    step(0, 0, 1, 0, 0, 8'hFE); lit("beq_not", 32'h20, 0, 0);
    step(0, 0, 0, 1, 1, 8'hFE); lit("bne_not", 32'h24, 0, 0);
    step(0, 1, 0, 0, 0, 8'hF8); lit("jmp_back", 32'h28, 0, 1);
    step(0, 0, 0, 0, 0, 8'h00); lit("jmp_back_tgt", 32'h0C, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 8'h00); lit("stall_run", 32'h10, 0, 0);
    end
    step(0, 1, 0, 0, 0, 8'h00); lit("stall_release", 32'h10, 0, 1);
    step(1, 0, 0, 0, 0, 8'h00); lit("stall_flush0", 32'h14, 1, 0);
    step(1, 0, 0, 0, 0, 8'h00); lit("stall_flush1", 32'h14, 1, 0);
    step(0, 0, 0, 0, 0, 8'h00); lit("flush_release", 32'h14, 1, 0);
    step(0, 1, 0, 0, 0, 8'hF6); lit("to_high", 32'h18, 0, 1);
    step(0, 0, 0, 0, 0, 8'h00); lit("high_tgt", 32'hFFFF_FFF4, 1, 0);
    step(0, 1, 0, 0, 0, 8'h01); lit("wrap_jmp", 32'hFFFF_FFF8, 0, 1);
    step(0, 1, 0, 0, 0, 8'h05); lit("wrap_tgt_squash", 32'h0, 1, 0);
    step(0, 1, 0, 0, 0, 8'h03); lit("after_squash", 32'h4, 0, 1);
    step(0, 0, 0, 0, 0, 8'h00); lit("pre_rst_flush", 32'h14, 1, 0);
    #2 rst_n = 1'b0;
    #1 lit("async_rst", RV, 1'b0, 1'b0);
`ifdef BRANCH_PC_STATS_EN
    check("async_rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    check("async_rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized phase, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom));
      if ($urandom_range(0, 249) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
